ac97_frame_tx: RTL and testbench
================================

Name: ac97_frame_tx

Overview:
AC'97 controller-side output serializer: the consumer end of the waveform generators' frame_sig/sample interface. It builds the 256-bit output frame on BIT_CLK, drives SYNC and SDATA_OUT to the codec, and pulses FRAME_SIG once per frame so generators advance one sample. It carries left/right PCM in slots 3/4 and one optional codec register write (slots 1/2) per frame.

Parameters:
PCM_W, 18, sample width; valid range 16..20; sample is MSB-aligned in its 20-bit slot and zero-padded below.

Ports:
BIT_CLK  in  1  12.288 MHz bit clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
PCM_L  in  PCM_W  left sample; goes to slot 3
PCM_R  in  PCM_W  right sample; goes to slot 4
PCM_EN  in  1  1 = slots 3/4 tagged valid and carry samples; 0 = slots 3/4 zero and untagged
CMD_VALID  in  1  register-write request
CMD_ADDR  in  7  codec register address
CMD_DATA  in  16  codec register data
CMD_READY  out  1  1 = no command pending; request is accepted on CMD_VALID & CMD_READY
CMD_SENT  out  1  1-cycle pulse after the last bit of slot 2 of a frame carrying a command
FRAME_SIG  out  1  1-cycle pulse, once per frame; connects to the generators' frame_sig
SYNC  out  1  AC'97 frame sync
SDATA_OUT  out  1  AC'97 serial data, MSB first

Behaviour:
- Internal 8-bit BIT_COUNT, 0..255, wraps 255 -> 0 every cycle. Frame bit k is on SDATA_OUT during the cycle where BIT_COUNT == k. SYNC = 1 iff k in 0..15 of a running frame. Both outputs are registered.
- Frame layout, bit index = position within the frame:
  - Slot 0 (tag): bits 0-15.
  - Slot 1: bits 16-35.
  - Slot 2: bits 36-55.
  - Slot 3: bits 56-75.
  - Slot 4: bits 76-95.
  - Slots 5-12: bits 96-255, always 0.
- Tag bits (bit 0 = tag[15]):
  - tag[15] = 1 (frame valid).
  - tag[14] = tag[13] = command present.
  - tag[12] = tag[11] = PCM_EN.
  - tag[10:2] = 0; tag[1:0] = 00 (primary codec).
- Slot 1 = {1'b0 (write), CMD_ADDR, 12'b0}. Slot 2 = {CMD_DATA, 4'b0}. Both are 0 when no command is present.
- Slot 3/4 = {PCM_x, (20-PCM_W) zeros}.
- Frame load edge = the rising edge where BIT_COUNT == 255. At this edge the 256-bit shift register loads the next frame from:
  - PCM_L, PCM_R and PCM_EN sampled at that edge;
  - the pending command register.
  Then it shifts one bit per cycle.
- FRAME_SIG = 1 during the cycle where BIT_COUNT == 255.
  - A generator updating on that edge presents its new sample after this block has already captured the old one.
  - Fixed latency: the sample produced in response to the pulse of frame N is transmitted in frame N+2's slot (captured at the next load edge, sent in the following frame).
- Command path:
  - On accept, CMD_ADDR/CMD_DATA are latched into the pending register and CMD_READY drops the next cycle.
  - The pending command is consumed at the next frame load edge; pending is cleared and CMD_READY rises the cycle after that edge.
  - A command accepted during the load-edge cycle itself (BIT_COUNT == 255, CMD_READY = 1) is loaded into the frame starting on that same edge.
  - At most one command per frame.
  - CMD_SENT pulses during the cycle with BIT_COUNT == 56 of a frame that carried a command.
- Reset, applied on any cycle including mid-frame:
  - BIT_COUNT = 0; shift register = 0; pending cleared.
  - SYNC = 0, SDATA_OUT = 0, FRAME_SIG = 0, CMD_SENT = 0, CMD_READY = 0.
  - CMD_READY = 1 from the first cycle after RESET deasserts.
  - The first post-reset pass of BIT_COUNT 0..255 is an idle frame: SYNC = 0, SDATA_OUT = 0. The first real frame loads at the edge ending that pass.
- A command in flight when RESET asserts is dropped; no CMD_SENT for it.
- CMD_VALID held without handshake is not latched; inputs are ignored while RESET is high.

Test Plan:
- Reset release, all inputs 0 -> 256 idle cycles with SYNC = 0; then SYNC high exactly 16 cycles per 256; tag = 16'h8000; FRAME_SIG pulses every 256 cycles aligned with BIT_COUNT == 255.
- PCM_EN = 1, PCM_L = 18'h3FFFF, PCM_R = 18'h00001 held -> tag 16'h9800; bits 56-73 = 1, 74-75 = 0; bits 76-92 = 0, bit 93 = 1, 94-95 = 0; bits 96-255 = 0.
- CMD_VALID with ADDR = 7'h02, DATA = 16'h0808, PCM_EN = 0 -> accepted in 1 cycle; next frame tag 16'hE000, slot 1 = 20'h02000, slot 2 = 20'h08080; CMD_SENT at BIT_COUNT 56; CMD_READY rises after the load edge; the following frame has tag 16'h8000.
- Back-to-back commands A, B with CMD_VALID held -> A in frame N, B in frame N+1, never both in one frame; exactly two CMD_SENT pulses.
- Sawtooth-style source, increments sample on FRAME_SIG -> slot 3 value in each frame equals the source value from before the previous pulse; consecutive frames differ by exactly one step.
- RESET asserted at BIT_COUNT = 40 with a command in frame -> outputs 0 the next cycle, no CMD_SENT, one idle frame, then normal framing resumes.

Source files
------------

// File: rtl/ac97_frame_tx_if.sv
// ac97_frame_tx_if: sample/command inputs and AC'97 link outputs of the frame serializer.
interface ac97_frame_tx_if #(
    parameter int PCM_W = 18
);
    logic [PCM_W-1:0] PCM_L;
    logic [PCM_W-1:0] PCM_R;
    logic             PCM_EN;
    logic             CMD_VALID;
    logic [6:0]       CMD_ADDR;
    logic [15:0]      CMD_DATA;
    logic             CMD_READY;
    logic             CMD_SENT;
    logic             FRAME_SIG;
    logic             SYNC;
    logic             SDATA_OUT;
    modport master (
        output PCM_L, PCM_R, PCM_EN, CMD_VALID, CMD_ADDR, CMD_DATA,
        input  CMD_READY, CMD_SENT, FRAME_SIG, SYNC, SDATA_OUT
    );
    modport slave (
        input  PCM_L, PCM_R, PCM_EN, CMD_VALID, CMD_ADDR, CMD_DATA,
        output CMD_READY, CMD_SENT, FRAME_SIG, SYNC, SDATA_OUT
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// ac97_frame_tx: builds the 256-bit AC'97 output frame, drives SYNC/SDATA_OUT and pulses FRAME_SIG per frame.
module ac97_frame_tx #(
    parameter int PCM_W = 18
) (
    input logic BIT_CLK,
    input logic RESET,
    ac97_frame_tx_if.slave bus
);
    localparam int PAD = 20 - PCM_W;
    logic [7:0]   bit_count;
    logic [255:0] shift_reg;
    logic [255:0] frame;
    logic         pend;
    logic         frame_cmd;
    logic [6:0]   pend_addr;
    logic [15:0]  pend_data;
    logic         load;
    logic         accept;
    logic         cmd_now;
    logic [6:0]   addr;
    logic [15:0]  data;
    logic [15:0]  tag;
    logic [19:0]  slot1;
    logic [19:0]  slot2;
    logic [19:0]  slot3;
    logic [19:0]  slot4;
    // A command accepted on the load edge itself bypasses the pending register.
    always_comb begin
        load    = bit_count == 8'd255;
        accept  = bus.CMD_VALID & bus.CMD_READY;
        cmd_now = pend | accept;
        addr    = pend ? pend_addr : bus.CMD_ADDR;
        data    = pend ? pend_data : bus.CMD_DATA;
        tag     = {1'b1, {2{cmd_now}}, {2{bus.PCM_EN}}, 11'b0};
        slot1   = cmd_now ? {1'b0, addr, 12'b0} : '0;
        slot2   = cmd_now ? {data, 4'b0} : '0;
        slot3   = bus.PCM_EN ? 20'(bus.PCM_L) << PAD : '0;
        slot4   = bus.PCM_EN ? 20'(bus.PCM_R) << PAD : '0;
        frame   = {tag, slot1, slot2, slot3, slot4, 160'b0};
    end
    always_ff @(posedge BIT_CLK) begin
        if (RESET) begin
            bit_count     <= '0;
            shift_reg     <= '0;
            pend          <= 1'b0;
            frame_cmd     <= 1'b0;
            pend_addr     <= '0;
            pend_data     <= '0;
            bus.SDATA_OUT <= 1'b0;
            bus.SYNC      <= 1'b0;
            bus.FRAME_SIG <= 1'b0;
            bus.CMD_SENT  <= 1'b0;
            bus.CMD_READY <= 1'b0;
        end else begin
            bit_count                  <= bit_count + 8'd1;
            {bus.SDATA_OUT, shift_reg} <= load ? {frame, 1'b0} : {shift_reg, 1'b0};
            bus.SYNC                   <= load | (bus.SYNC & (bit_count < 8'd15));
            bus.FRAME_SIG              <= bit_count == 8'd254;
            bus.CMD_SENT               <= frame_cmd & (bit_count == 8'd55);
            bus.CMD_READY              <= load | ~cmd_now;
            pend                       <= ~load & cmd_now;
            if (load)
                frame_cmd <= cmd_now;
            if (accept) begin
                pend_addr <= bus.CMD_ADDR;
                pend_data <= bus.CMD_DATA;
            end
        end
    end
endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb_ac97_frame_tx: table vectors, corner sequences and random traffic against a frame-level reference model.
module tb_ac97_frame_tx;
    localparam int PW = 18;
    logic BIT_CLK = 1'b0;
    logic RESET = 1'b1;
    ac97_frame_tx_if #(.PCM_W(PW)) bus ();
    ac97_frame_tx #(.PCM_W(PW)) dut (.BIT_CLK(BIT_CLK), .RESET(RESET), .bus(bus.slave));
    always #5 BIT_CLK = ~BIT_CLK;

    typedef struct {
        logic en; logic [17:0] l; logic [17:0] r;
        logic cv; logic [6:0] a; logic [15:0] d;
        logic [15:0] tag; logic [19:0] s1; logic [19:0] s2; logic [19:0] s3; logic [19:0] s4;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int cnt = 0, frames = 0, sent_cnt = 0, sync_cnt = 0, fs_cnt = 0;
    bit running = 0, cur_cmd = 0, m_ready = 0, last_acc = 0, saw_on = 0;
    logic [22:0] q[$];
    logic [0:255] exp_frame, cap, last_frame;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t cnt=%0d)", nm, act, want, $time, cnt);
        end
    endtask

    task automatic chk256(input string nm, input logic [0:255] act, input logic [0:255] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Frame assembled bit by bit from the slot map: bit 0 is the first bit on the wire.
    function automatic logic [0:255] build(input logic en, input logic [17:0] l, input logic [17:0] r,
                                           input logic c, input logic [6:0] a, input logic [15:0] d);
        logic [0:255] f = '0;
        f[0] = 1'b1; f[1] = c; f[2] = c; f[3] = en; f[4] = en;
        if (c) begin
            for (int i = 0; i < 7; i++) f[17 + i] = a[6 - i];
            for (int i = 0; i < 16; i++) f[36 + i] = d[15 - i];
        end
        if (en) begin
            for (int i = 0; i < PW; i++) f[56 + i] = l[PW - 1 - i];
            for (int i = 0; i < PW; i++) f[76 + i] = r[PW - 1 - i];
        end
        return f;
    endfunction

    task automatic step();
        logic rs, ld, acc, fs, en;
        logic [17:0] l, r;
        logic [22:0] cv, cw;
        rs = RESET; ld = !rs && cnt == 255; fs = bus.FRAME_SIG;
        acc = !rs && bus.CMD_VALID && m_ready;
        en = bus.PCM_EN; l = bus.PCM_L; r = bus.PCM_R; cv = {bus.CMD_ADDR, bus.CMD_DATA};
        @(posedge BIT_CLK);
        #1;
        last_acc = acc;
        if (rs) begin
            cnt = 0; running = 0; cur_cmd = 0; m_ready = 0; q.delete();
        end else begin
            if (acc) q.push_back(cv);
            if (ld) begin
                cur_cmd = q.size() != 0;
                cw = cur_cmd ? q.pop_front() : '0;
                exp_frame = build(en, l, r, cur_cmd, cw[22:16], cw[15:0]);
                running = 1;
            end
            m_ready = q.size() == 0;
            cnt = (cnt + 1) % 256;
        end
        if (saw_on && fs && !rs) bus.PCM_L = bus.PCM_L + 1'b1;
        chk("sync", bus.SYNC, running && cnt < 16);
        chk("frame_sig", bus.FRAME_SIG, cnt == 255);
        chk("cmd_sent", bus.CMD_SENT, running && cur_cmd && cnt == 56);
        chk("cmd_ready", bus.CMD_READY, m_ready);
        if (!running) chk("idle_sdata", bus.SDATA_OUT, 0);
        else cap[cnt] = bus.SDATA_OUT;
        if (running && cnt == 255) begin
            chk256("frame", cap, exp_frame);
            last_frame = cap;
            frames++;
        end
        if (bus.CMD_SENT === 1'b1) sent_cnt++;
        if (bus.SYNC === 1'b1) sync_cnt++;
        if (bus.FRAME_SIG === 1'b1) fs_cnt++;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (cnt != k && n < 1000) begin
            step();
            n++;
        end
        if (cnt != k) chk("wait_timeout", cnt, k);
    endtask

    vec_t tbl[5];
    int s0, f0, nacc;
    logic [17:0] prev, cur;

    initial begin
        tbl[0] = '{1'b0, 18'h0, 18'h0, 1'b0, 7'h00, 16'h0000, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h0};
        tbl[1] = '{1'b1, 18'h3FFFF, 18'h00001, 1'b0, 7'h00, 16'h0000, 16'h9800, 20'h0, 20'h0, 20'hFFFFC, 20'h00004};
        tbl[2] = '{1'b0, 18'h0, 18'h0, 1'b1, 7'h02, 16'h0808, 16'hE000, 20'h02000, 20'h08080, 20'h0, 20'h0};
        tbl[3] = '{1'b1, 18'h20000, 18'h1FFFF, 1'b1, 7'h7F, 16'hFFFF, 16'hF800, 20'h7F000, 20'hFFFF0, 20'h80000, 20'h7FFFC};
        tbl[4] = '{1'b0, 18'h12345, 18'h2ABCD, 1'b0, 7'h00, 16'h0000, 16'h8000, 20'h0, 20'h0, 20'h0, 20'h0};
        bus.PCM_L = '0; bus.PCM_R = '0; bus.PCM_EN = 1'b0;
        bus.CMD_VALID = 1'b1; bus.CMD_ADDR = 7'h55; bus.CMD_DATA = 16'hABCD;
        repeat (3) step();
        chk("rst_ready", bus.CMD_READY, 0);
        chk("rst_sdata", bus.SDATA_OUT, 0);
        bus.CMD_VALID = 1'b0;
        RESET = 1'b0;
        step();
        chk("ready_after_rst", bus.CMD_READY, 1);
        sync_cnt = 0;
        wait_cnt(255);
        chk("idle_sync", sync_cnt, 0);
        chk("idle_frames", frames, 0);
        s0 = sync_cnt; f0 = fs_cnt;
        repeat (256) step();
        chk("sync_16", sync_cnt - s0, 16);
        chk("fs_once", fs_cnt - f0, 1);
        chk("first_tag", last_frame[0:15], 16'h8000);

        foreach (tbl[i]) begin
            wait_cnt(100);
            bus.PCM_EN = tbl[i].en; bus.PCM_L = tbl[i].l; bus.PCM_R = tbl[i].r;
            bus.CMD_VALID = tbl[i].cv; bus.CMD_ADDR = tbl[i].a; bus.CMD_DATA = tbl[i].d;
            step();
            bus.CMD_VALID = 1'b0;
            chk("tbl_ready", bus.CMD_READY, !tbl[i].cv);
            wait_cnt(255);
            step();
            s0 = sent_cnt;
            wait_cnt(255);
            chk("tbl_tag", last_frame[0:15], tbl[i].tag);
            chk("tbl_s1", last_frame[16:35], tbl[i].s1);
            chk("tbl_s2", last_frame[36:55], tbl[i].s2);
            chk("tbl_s3", last_frame[56:75], tbl[i].s3);
            chk("tbl_s4", last_frame[76:95], tbl[i].s4);
            chk("tbl_tail", last_frame[96:255] == '0, 1);
            chk("tbl_sent", sent_cnt - s0, tbl[i].cv);
        end

        bus.PCM_EN = 1'b0;
        wait_cnt(100);
        bus.CMD_VALID = 1'b1; bus.CMD_ADDR = 7'h0A; bus.CMD_DATA = 16'h1111;
        s0 = sent_cnt; nacc = 0;
        for (int i = 0; i < 800 && nacc < 2; i++) begin
            step();
            if (last_acc) begin
                nacc++;
                bus.CMD_ADDR = 7'h0B; bus.CMD_DATA = 16'h2222;
            end
        end
        bus.CMD_VALID = 1'b0;
        chk("b2b_accepts", nacc, 2);
        repeat (768) step();
        chk("b2b_sent", sent_cnt - s0, 2);

        wait_cnt(100);
        bus.PCM_EN = 1'b1; bus.PCM_L = 18'd100; bus.PCM_R = 18'h0; saw_on = 1;
        for (int f = 0; f < 7; f++) begin
            step();
            wait_cnt(255);
            cur = last_frame[56:73];
            if (f == 1) chk("saw_first", cur, 100);
            if (f >= 2) chk("saw_step", cur, prev + 1'b1);
            prev = cur;
        end
        saw_on = 0;

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.PCM_L = 18'($urandom); bus.PCM_R = 18'($urandom); bus.PCM_EN = 1'($urandom);
            end
            if (!bus.CMD_VALID && $urandom_range(0, 99) == 0) begin
                bus.CMD_VALID = 1'b1; bus.CMD_ADDR = 7'($urandom); bus.CMD_DATA = 16'($urandom);
            end
            step();
            if (last_acc) bus.CMD_VALID = 1'b0;
        end
        bus.CMD_VALID = 1'b0; bus.PCM_EN = 1'b0;

        wait_cnt(100);
        bus.CMD_VALID = 1'b1; bus.CMD_ADDR = 7'h26; bus.CMD_DATA = 16'h1234;
        step();
        bus.CMD_VALID = 1'b0;
        wait_cnt(255);
        step();
        chk("mid_cmd_loaded", cur_cmd, 1);
        wait_cnt(40);
        s0 = sent_cnt; f0 = frames;
        RESET = 1'b1;
        step();
        chk("mid_rst_sdata", bus.SDATA_OUT, 0);
        chk("mid_rst_ready", bus.CMD_READY, 0);
        RESET = 1'b0;
        repeat (522) step();
        chk("mid_rst_no_sent", sent_cnt - s0, 0);
        chk("mid_rst_frames", frames - f0, 1);
        chk("mid_rst_tag", last_frame[0:15], 16'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
